// File: rtl/ball_direction.sv
// Per-frame ball direction and serve controller: latches ball/paddle/wall events while the
// frame is drawn and commits them on the first clock of vertical blank. Optional BALL_SPEEDUP_EN.
`timescale 1ns/1ps
`ifndef H_VISIBLE_AREA
`define H_VISIBLE_AREA 640
`endif
`ifndef V_VISIBLE_AREA
`define V_VISIBLE_AREA 480
`endif

module ball_direction #(
  parameter int p_SERVE_FRAMES = 60,
  parameter int p_SPEED        = 1
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_HReset,
  input  logic       i_VReset,
  input  logic       i_HBlank,
  input  logic       i_VBlank,
  input  logic       i_Ball_Video,
  input  logic       i_PaddleL_Video,
  input  logic       i_PaddleR_Video,
  output logic       o_HDir,
  output logic       o_VDir,
  output logic       o_Freeze,
  output logic       o_ScoreL,
  output logic       o_ScoreR,
  output logic [2:0] o_Speed
);
  localparam int H_W = $clog2(`H_VISIBLE_AREA);
  localparam int V_W = $clog2(`V_VISIBLE_AREA);
  localparam logic [H_W-1:0] COL_LAST   = H_W'(`H_VISIBLE_AREA - 1);
  localparam logic [V_W-1:0] ROW_LAST   = V_W'(`V_VISIBLE_AREA - 1);
  localparam logic [7:0]     SERVE_LOAD = 8'(p_SERVE_FRAMES);
  localparam logic [2:0]     SPEED_INIT = 3'(p_SPEED);

  typedef enum logic {SERVE = 1'b0, PLAY = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [H_W-1:0] col_q;
  logic [V_W-1:0] row_q;
  logic           vblank_p1, armed_q;
  logic           hit_l_q, hit_r_q, top_q, bot_q, miss_l_q, miss_r_q;
  logic [7:0]     serve_cnt_q, serve_cnt_d;
  logic           hdir_q, hdir_d, vdir_q, vdir_d;
  logic           score_l_q, score_l_d, score_r_q, score_r_d;
  logic           freeze_q;
  logic           commit, ball_vis, lost;

  // armed_q blocks a commit until VBlank has been seen low since reset
  assign commit   = i_VBlank && !vblank_p1 && armed_q;
  assign ball_vis = !i_HBlank && !i_VBlank && i_Ball_Video;
  assign lost     = (miss_l_q && !hit_l_q) || (miss_r_q && !hit_r_q);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      if (i_HReset)       col_q <= '0;
      else if (!i_HBlank) col_q <= col_q + 1'b1;
      if (i_VReset)                    row_q <= '0;
      else if (i_HReset && !i_VBlank)  row_q <= row_q + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      vblank_p1 <= 1'b0;
      armed_q   <= 1'b0;
      hit_l_q   <= 1'b0;
      hit_r_q   <= 1'b0;
      top_q     <= 1'b0;
      bot_q     <= 1'b0;
      miss_l_q  <= 1'b0;
      miss_r_q  <= 1'b0;
    end else begin
      vblank_p1 <= i_VBlank;
      if (!i_VBlank) armed_q <= 1'b1;
      if (commit) begin
        hit_l_q  <= 1'b0;
        hit_r_q  <= 1'b0;
        top_q    <= 1'b0;
        bot_q    <= 1'b0;
        miss_l_q <= 1'b0;
        miss_r_q <= 1'b0;
      end else if (ball_vis) begin
        hit_l_q  <= hit_l_q  | i_PaddleL_Video;
        hit_r_q  <= hit_r_q  | i_PaddleR_Video;
        top_q    <= top_q    | (row_q == '0);
        bot_q    <= bot_q    | (row_q == ROW_LAST);
        miss_l_q <= miss_l_q | (col_q == '0);
        miss_r_q <= miss_r_q | (col_q == COL_LAST);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    hdir_d      = hdir_q;
    vdir_d      = vdir_q;
    score_l_d   = 1'b0;
    score_r_d   = 1'b0;
    if (commit) begin
      if (state_q == SERVE) begin
        if (serve_cnt_q == 8'd0) state_d = PLAY;
        else                     serve_cnt_d = serve_cnt_q - 8'd1;
      end else if (miss_l_q && !hit_l_q) begin
        score_r_d   = 1'b1;
        hdir_d      = 1'b1;
        serve_cnt_d = SERVE_LOAD;
        state_d     = SERVE;
      end else if (miss_r_q && !hit_r_q) begin
        score_l_d   = 1'b1;
        hdir_d      = 1'b0;
        serve_cnt_d = SERVE_LOAD;
        state_d     = SERVE;
      end else begin
        if (hit_l_q)      hdir_d = 1'b0;
        else if (hit_r_q) hdir_d = 1'b1;
        if (top_q)        vdir_d = 1'b0;
        else if (bot_q)   vdir_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= SERVE;
      serve_cnt_q <= SERVE_LOAD;
      hdir_q      <= 1'b0;
      vdir_q      <= 1'b0;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
      freeze_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      hdir_q      <= hdir_d;
      vdir_q      <= vdir_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      freeze_q    <= (state_d == SERVE);
    end
  end

  assign o_HDir   = hdir_q;
  assign o_VDir   = vdir_q;
  assign o_Freeze = freeze_q;
  assign o_ScoreL = score_l_q;
  assign o_ScoreR = score_r_q;

`ifdef BALL_SPEEDUP_EN
  logic [1:0] rally_q;
  logic [2:0] speed_q;
  logic       hit_evt, miss_evt;

  assign miss_evt = commit && (state_q == PLAY) && lost;
  assign hit_evt  = commit && (state_q == PLAY) && !lost && (hit_l_q || hit_r_q);

  // every fourth rally hit wraps the counter and bumps the speed, saturating at 7
  always_ff @(posedge i_Clk) begin
    if (i_Reset || miss_evt) begin
      rally_q <= 2'd0;
      speed_q <= SPEED_INIT;
    end else if (hit_evt) begin
      rally_q <= rally_q + 2'd1;
      if (rally_q == 2'd3 && speed_q != 3'd7) speed_q <= speed_q + 3'd1;
    end
  end

  assign o_Speed = speed_q;
`else
  assign o_Speed = SPEED_INIT;
`endif

endmodule

// File: tb/tb_ball_direction.sv
// Scoreboard bench for ball_direction: randomized frames against a frame-level reference model.
// Honours BALL_SPEEDUP_EN when defined for the whole build.
`timescale 1ns/1ps
`ifndef H_VISIBLE_AREA
`define H_VISIBLE_AREA 640
`endif
`ifndef V_VISIBLE_AREA
`define V_VISIBLE_AREA 480
`endif

module tb_ball_direction;
  localparam int H_VIS   = `H_VISIBLE_AREA;
  localparam int V_VIS   = `V_VISIBLE_AREA;
  localparam int P_SERVE = 60;
  localparam int P_SPEED = 1;

  logic       clk = 1'b0;
  logic       rst, hreset, vreset, hblank, vblank, ball, padl, padr;
  logic       hdir, vdir, freeze, scl, scr;
  logic [2:0] speed;

  always #5 clk = ~clk;

  ball_direction #(.p_SERVE_FRAMES(P_SERVE), .p_SPEED(P_SPEED)) dut (
    .i_Clk(clk), .i_Reset(rst), .i_HReset(hreset), .i_VReset(vreset),
    .i_HBlank(hblank), .i_VBlank(vblank), .i_Ball_Video(ball),
    .i_PaddleL_Video(padl), .i_PaddleR_Video(padr),
    .o_HDir(hdir), .o_VDir(vdir), .o_Freeze(freeze),
    .o_ScoreL(scl), .o_ScoreR(scr), .o_Speed(speed)
  );

  typedef struct packed {
    logic       hdir, vdir, freeze, sl, sr;
    logic [2:0] speed;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void chk(string name, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // Reference model: one call per frame, working from the frame's event summary.
  bit m_play;
  int m_cnt, m_hits;
  bit m_hdir, m_vdir;

  function automatic void model_reset();
    m_play = 0; m_cnt = P_SERVE; m_hdir = 0; m_vdir = 0; m_hits = 0;
  endfunction

  function automatic int model_speed();
`ifdef BALL_SPEEDUP_EN
    int s = P_SPEED + m_hits / 4;
    return (s > 7) ? 7 : s;
`else
    return P_SPEED;
`endif
  endfunction

  function automatic void model_commit(bit hl, bit hr, bit tp, bit bt, bit ml, bit mr);
    exp_t e;
    e.sl = 0; e.sr = 0;
    if (!m_play) begin
      if (m_cnt == 0) m_play = 1; else m_cnt--;
    end else if (ml && !hl) begin
      e.sr = 1; m_hdir = 1; m_play = 0; m_cnt = P_SERVE; m_hits = 0;
    end else if (mr && !hr) begin
      e.sl = 1; m_hdir = 0; m_play = 0; m_cnt = P_SERVE; m_hits = 0;
    end else begin
      if (hl) m_hdir = 0; else if (hr) m_hdir = 1;
      if (tp) m_vdir = 0; else if (bt) m_vdir = 1;
      if (hl || hr) m_hits++;
    end
    e.hdir = m_hdir; e.vdir = m_vdir; e.freeze = !m_play;
    e.speed = 3'(model_speed());
    exp_q.push_back(e);
  endfunction

  // Ball pixels of the next frame
  int npix;
  int px_row[4], px_col[4];
  bit px_l[4], px_r[4];

  function automatic void set_pix1(int r, int c, bit l, bit rr);
    npix = 1; px_row[0] = r; px_col[0] = c; px_l[0] = l; px_r[0] = rr;
  endfunction

  function automatic void gen_random();
    npix = $urandom_range(0, 2);
    for (int i = 0; i < npix; i++) begin
      int rs = $urandom_range(0, 39);
      int cs = $urandom_range(0, 7);
      px_row[i] = (rs == 0) ? V_VIS - 1 : (rs <= 6) ? 0 : $urandom_range(1, 2);
      px_col[i] = (cs == 0) ? 0 : (cs == 1) ? H_VIS - 1 : $urandom_range(1, 4);
      px_l[i]   = ($urandom_range(0, 3) == 0);
      px_r[i]   = ($urandom_range(0, 3) == 0);
    end
  endfunction

  task automatic noise();
    ball = 1'($urandom_range(0, 1));
    padl = 1'($urandom_range(0, 1));
    padr = 1'($urandom_range(0, 1));
  endtask

  // Draws one frame; rst_line >= 0 pulses i_Reset mid-way through that line.
  task automatic run_frame(input int rst_line);
    bit hl, hr, tp, bt, ml, mr, b, lm, rm;
    int nrows, ncols;
    hl = 0; hr = 0; tp = 0; bt = 0; ml = 0; mr = 0; nrows = 3;
    for (int i = 0; i < npix; i++) begin
      hl |= px_l[i]; hr |= px_r[i];
      tp |= (px_row[i] == 0); bt |= (px_row[i] == V_VIS - 1);
      ml |= (px_col[i] == 0); mr |= (px_col[i] == H_VIS - 1);
      if (px_row[i] + 1 > nrows) nrows = px_row[i] + 1;
    end
    model_commit(hl, hr, tp, bt, ml, mr);
    for (int r = 0; r < nrows; r++) begin
      ncols = 6;
      for (int i = 0; i < npix; i++)
        if (px_row[i] == r && px_col[i] == H_VIS - 1) ncols = H_VIS;
      @(posedge clk); #1;
      vblank = 0; hblank = 1; hreset = 1; vreset = (r == 0); noise();
      for (int c = 0; c < ncols; c++) begin
        @(posedge clk); #1;
        hreset = 0; vreset = 0; hblank = 0;
        b = 0; lm = 0; rm = 0;
        for (int i = 0; i < npix; i++)
          if (px_row[i] == r && px_col[i] == c) begin b = 1; lm |= px_l[i]; rm |= px_r[i]; end
        ball = b;
        padl = b ? lm : 1'($urandom_range(0, 1));
        padr = b ? rm : 1'($urandom_range(0, 1));
        rst = (r == rst_line && c == 4);
        if (rst) begin
          model_reset();
          exp_q.delete();
          model_commit(0, 0, 0, 0, 0, 0);
        end
      end
      @(posedge clk); #1;
      rst = 0; hblank = 1; noise();
    end
    @(posedge clk); #1;
    vblank = 1; noise();
    repeat (3) begin @(posedge clk); #1; noise(); end
  endtask

  task automatic idle(input int n);
    npix = 0;
    repeat (n) run_frame(-1);
  endtask

  // Monitor: pops one expectation per commit, otherwise outputs must hold.
  bit         pend = 0, vb_prev = 1;
  bit         lh = 0, lv = 0, lf = 1;
  logic [2:0] ls = 3'(P_SPEED);
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      lh = 0; lv = 0; lf = 1; ls = 3'(P_SPEED); pend = 0; vb_prev = 1;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) chk("commit_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("hdir_commit", hdir, e.hdir);
          chk("vdir_commit", vdir, e.vdir);
          chk("freeze_commit", freeze, e.freeze);
          chk("speed_commit", speed, e.speed);
          chk("scoreL_commit", scl, e.sl);
          chk("scoreR_commit", scr, e.sr);
          lh = e.hdir; lv = e.vdir; lf = e.freeze; ls = e.speed;
        end
      end else begin
        chk("hdir_hold", hdir, lh);
        chk("vdir_hold", vdir, lv);
        chk("freeze_hold", freeze, lf);
        chk("speed_hold", speed, ls);
        chk("scoreL_idle", scl, 0);
        chk("scoreR_idle", scr, 0);
      end
      pend = vblank && !vb_prev;
      vb_prev = vblank;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; vblank = 1; hblank = 1; hreset = 0; vreset = 0; ball = 0; padl = 0; padr = 0;
    model_reset();
    repeat (4) @(posedge clk);
    #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;
    idle(61);                                  // serve countdown, then PLAY
    set_pix1(1, 2, 0, 1);         run_frame(-1); // right paddle -> move left
    set_pix1(1, 2, 1, 0);         run_frame(-1); // left paddle -> move right
    set_pix1(0, 2, 0, 0);         run_frame(-1); // top wall
    set_pix1(V_VIS - 1, 3, 0, 0); run_frame(-1); // bottom wall
    set_pix1(0, 0, 0, 0);         run_frame(-1); // left miss at top row
    idle(61);
    set_pix1(1, 2, 1, 0);         run_frame(-1);
    set_pix1(1, H_VIS - 1, 0, 1); run_frame(-1); // right edge saved by paddle
    set_pix1(1, H_VIS - 1, 0, 0); run_frame(-1); // right miss
    idle(61);
    for (int k = 0; k < 150; k++) begin
      gen_random();
      run_frame(-1);
    end
    set_pix1(0, 0, 0, 0);         run_frame(1);  // reset mid-frame with flags set
    idle(60);
    for (int k = 0; k < 8; k++) begin
      set_pix1(1, 2, 1, 0);
      run_frame(-1);
    end
    set_pix1(1, 0, 0, 0);         run_frame(-1);
    idle(2);
    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
